// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Receive-side monitor for a 4-digit multiplexed, active-low 7-segment bus.
//   It captures each slot once its anode/segment pattern has been stable long
//   enough, assembles complete 4-slot frames and publishes price/balance or a
//   text mode once MATCH_FRAMES identical frames have been seen.
//
//   Optional build macro: SEGDEC_SYNC_EN adds 2-flop input synchronizers,
//   which adds 2 cycles to every latency.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   digit_in[3:0]     anodes, active-low one-hot, bit k = slot k
//   display_in[6:0]   segments, active-low, bit0=a .. bit6=g
//   price[6:0]        slot3*10+slot2 (numeric mode)
//   balance[6:0]      slot1*10+slot0 (numeric mode)
//   mode[1:0]         0 none/lost, 1 numeric, 2 SODA, 3 TEAA
//   frame_valid       one-cycle pulse per publish
//   locked            FSM is in LOCKED
//   glyph_err         sticky error, cleared by the next publish
module sevenseg_scan_decoder #(
  parameter int SETTLE_CYC   = 4,
  parameter int MATCH_FRAMES = 2,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic [6:0] display_in,
  output logic [6:0] price,
  output logic [6:0] balance,
  output logic [1:0] mode,
  output logic       frame_valid,
  output logic       locked,
  output logic       glyph_err
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int MCW = $clog2(MATCH_FRAMES + 1);
  localparam int TW  = 16;

  typedef enum logic [1:0] {ST_LOST, ST_ACQ, ST_LOCKED} state_e;

  logic [10:0] smp;

`ifdef SEGDEC_SYNC_EN
  logic [10:0] sync1_q, sync2_q;
  // Reset to all-ones so the idle (blank) bus is what the decoder sees first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {digit_in, display_in};
      sync2_q <= sync1_q;
    end
  end
  assign smp = sync2_q;
`else
  assign smp = {digit_in, display_in};
`endif

  // Returns {known, code}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      7'b0100000: return {1'b1, 4'd10}; // A
      7'b0100001: return {1'b1, 4'd11}; // D
      7'b0000110: return {1'b1, 4'd12}; // E
      7'b1010010: return {1'b1, 4'd13}; // S
      7'b0000111: return {1'b1, 4'd14}; // T
      7'b0011000: return {1'b1, 4'd15}; // O
      default:    return 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] tens_units(input logic [3:0] t, input logic [3:0] u);
    return ({3'b0, t} << 3) + ({3'b0, t} << 1) + {3'b0, u};
  endfunction

  state_e            state_q, state_d;
  logic [10:0]       samp_q, samp_d;
  logic [SCW-1:0]    settle_q, settle_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        mask_q, mask_d, mask_nxt;
  logic [3:0][3:0]   slots_q, slots_d, slots_nxt;
  logic [3:0][3:0]   frm_q, frm_d;
  logic              frm_vld_q, frm_vld_d;
  logic [MCW-1:0]    match_q, match_d, match_inc, match_new;
  logic [6:0]        price_q, price_d, bal_q, bal_d;
  logic [1:0]        mode_q, mode_d, f_mode;
  logic              fv_q, fv_d, err_q, err_d;
  logic              hit, one_hot, g_ok, all_dig;
  logic [3:0]        an, g_code;
  logic [1:0]        k;

  always_comb begin
    state_d   = state_q;
    samp_d    = smp;
    timer_d   = timer_q;
    mask_d    = mask_q;
    slots_d   = slots_q;
    frm_d     = frm_q;
    frm_vld_d = frm_vld_q;
    match_d   = match_q;
    price_d   = price_q;
    bal_d     = bal_q;
    mode_d    = mode_q;
    fv_d      = 1'b0;
    err_d     = err_q;

    // Settle counter: restarts on any bus change, saturates at SETTLE_CYC so
    // a held pattern captures exactly once.
    if (smp != samp_q)                          settle_d = '0;
    else if (settle_q == SCW'(SETTLE_CYC))      settle_d = settle_q;
    else                                        settle_d = settle_q + 1'b1;
    hit = (smp == samp_q) && (settle_q == SCW'(SETTLE_CYC - 1));

    an      = ~smp[10:7];
    one_hot = $onehot(an);
    {g_ok, g_code} = seg_decode(smp[6:0]);
    k = 2'd0;
    for (int i = 0; i < 4; i++) if (an[i]) k = 2'(i);

    slots_nxt    = slots_q;
    slots_nxt[k] = g_code;
    mask_nxt     = mask_q | (4'b0001 << k);

    all_dig = 1'b1;
    for (int i = 0; i < 4; i++) if (slots_nxt[i] > 4'd9) all_dig = 1'b0;
    if (slots_nxt == {4'd13, 4'd15, 4'd11, 4'd10})      f_mode = 2'd2;
    else if (slots_nxt == {4'd14, 4'd12, 4'd10, 4'd10}) f_mode = 2'd3;
    else if (all_dig)                                   f_mode = 2'd1;
    else                                                f_mode = 2'd0;

    match_inc = (match_q >= MCW'(MATCH_FRAMES)) ? match_q : match_q + 1'b1;
    match_new = (frm_vld_q && slots_nxt == frm_q) ? match_inc : MCW'(1);

    if (hit && one_hot) begin
      timer_d = '0;
      if (state_q == ST_LOST) begin
        state_d = ST_ACQ;
        match_d = '0;
      end
      if (!g_ok) begin
        err_d  = 1'b1;
        mask_d = '0;
      end else begin
        slots_d = slots_nxt;
        if (mask_nxt == 4'hF) begin
          mask_d = '0;
          if (f_mode == 2'd0) begin
            err_d = 1'b1;
          end else if (state_q == ST_LOCKED) begin
            // frm_q holds the published frame while LOCKED.
            if (slots_nxt != frm_q) begin
              state_d = ST_ACQ;
              match_d = MCW'(1);
              frm_d   = slots_nxt;
            end
          end else begin
            match_d   = match_new;
            frm_d     = slots_nxt;
            frm_vld_d = 1'b1;
            if (match_new >= MCW'(MATCH_FRAMES)) begin
              state_d = ST_LOCKED;
              fv_d    = 1'b1;
              err_d   = 1'b0;
              mode_d  = f_mode;
              if (f_mode == 2'd1) begin
                price_d = tens_units(slots_nxt[3], slots_nxt[2]);
                bal_d   = tens_units(slots_nxt[1], slots_nxt[0]);
              end
            end
          end
        end else begin
          mask_d = mask_nxt;
        end
      end
    end else begin
      if (hit && an != 4'd0) err_d = 1'b1;  // multi-hot anode
      if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        timer_d   = '0;
        state_d   = ST_LOST;
        mode_d    = 2'd0;
        mask_d    = '0;
        match_d   = '0;
        frm_vld_d = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOST;
      samp_q    <= '1;
      settle_q  <= '0;
      timer_q   <= '0;
      mask_q    <= '0;
      slots_q   <= '0;
      frm_q     <= '0;
      frm_vld_q <= 1'b0;
      match_q   <= '0;
      price_q   <= '0;
      bal_q     <= '0;
      mode_q    <= '0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      mask_q    <= mask_d;
      slots_q   <= slots_d;
      frm_q     <= frm_d;
      frm_vld_q <= frm_vld_d;
      match_q   <= match_d;
      price_q   <= price_d;
      bal_q     <= bal_d;
      mode_q    <= mode_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
    end
  end

  assign price       = price_q;
  assign balance     = bal_q;
  assign mode        = mode_q;
  assign frame_valid = fv_q;
  assign locked      = (state_q == ST_LOCKED);
  assign glyph_err   = err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: a table of frame scans with
// hand-computed outputs, then hand sequences for multi-hot anode, timeout,
// sub-settle glitches and mid-frame reset.
module tb_sevenseg_scan_decoder;
  localparam int TO = 4096;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D5 = 7'b0010010, D7 = 7'b1111000;
  localparam logic [6:0] GA = 7'b0100000, GD = 7'b0100001, GE = 7'b0000110,
                         GS = 7'b1010010, GT = 7'b0000111, GO = 7'b0011000,
                         BAD = 7'b1111111;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] digit_in = 4'hF;
  logic [6:0] display_in = 7'h7F;
  logic [6:0] price, balance;
  logic [1:0] mode;
  logic       frame_valid, locked, glyph_err;

  int n_cmp = 0, n_bad = 0, fv_cnt = 0;

  sevenseg_scan_decoder #(.SETTLE_CYC(4), .MATCH_FRAMES(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .display_in(display_in),
    .price(price), .balance(balance), .mode(mode), .frame_valid(frame_valid),
    .locked(locked), .glyph_err(glyph_err));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (frame_valid) fv_cnt++;
  end

  typedef struct {
    logic [3:0][6:0] g;
    int              nfr;
    int              price, bal, mode, lk, err, fv;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] s3, s2, s1, s0, input int nfr,
                              input int p, b, m, lk, err, fv);
    vec_t v;
    v.g = {s3, s2, s1, s0};
    v.nfr = nfr; v.price = p; v.bal = b; v.mode = m; v.lk = lk; v.err = err; v.fv = fv;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p, b, m, lk, err);
    chk({tag, " price"}, price, p);
    chk({tag, " balance"}, balance, b);
    chk({tag, " mode"}, mode, m);
    chk({tag, " locked"}, locked, lk);
    chk({tag, " glyph_err"}, glyph_err, err);
  endtask

  // Called aligned to a negedge; holds the pattern for n rising edges.
  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    digit_in = d;
    display_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [3:0][6:0] g, input int nfr, input bit glitch);
    for (int f = 0; f < nfr; f++)
      for (int k = 0; k < 4; k++) begin
        if (glitch) drive(4'b1110, BAD, 3);  // one cycle short of settling
        drive(~(4'b0001 << k), g[k], 16);
      end
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = mk(D2, D0, D1, D5, 2, 20, 15, 1, 1, 0, 1);
    vt[1]  = mk(GS, GO, GD, GA, 2, 20, 15, 2, 1, 0, 1);
    vt[2]  = mk(GT, GE, GA, GA, 2, 20, 15, 3, 1, 0, 1);
    vt[3]  = mk(D2, D0, D1, D5, 2, 20, 15, 1, 1, 0, 1);
    vt[4]  = mk(D2, D0, D2, D5, 2, 20, 25, 1, 1, 0, 1);
    vt[5]  = mk(D2, D0, D2, D7, 1, 20, 25, 1, 0, 0, 0);
    vt[6]  = mk(D2, D0, D2, D7, 1, 20, 27, 1, 1, 0, 1);
    vt[7]  = mk(D2, BAD, D1, D5, 1, 20, 27, 1, 1, 1, 0);
    vt[8]  = mk(D2, D0, D1, D5, 2, 20, 15, 1, 1, 0, 1);
    vt[9]  = mk(D2, D0, D1, GA, 1, 20, 15, 1, 1, 1, 0);
    vt[10] = mk(D2, D0, D2, D5, 2, 20, 25, 1, 1, 0, 1);

    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset frame_valid", frame_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[i]) begin
      fv_cnt = 0;
      scan(vt[i].g, vt[i].nfr, 1'b0);
      chk_all($sformatf("vec%0d", i), vt[i].price, vt[i].bal, vt[i].mode, vt[i].lk, vt[i].err);
      chk($sformatf("vec%0d pulses", i), fv_cnt, vt[i].fv);
    end

    // Multi-hot anode: error only, nothing captured or published.
    fv_cnt = 0;
    drive(4'b1100, D0, 16);
    chk_all("multihot", 20, 25, 1, 1, 1);
    chk("multihot pulses", fv_cnt, 0);

    // Loss of signal: still locked well inside the window, lost after it.
    drive(4'b1111, BAD, TO - 200);
    chk("pre-timeout locked", locked, 1);
    chk("pre-timeout mode", mode, 1);
    drive(4'b1111, BAD, 300);
    chk_all("timeout", 20, 25, 0, 0, 1);

    // 3-cycle glitches of an unknown glyph between slots must never capture.
    fv_cnt = 0;
    scan({D2, D0, D1, D5}, 2, 1'b1);
    chk_all("glitch", 20, 15, 1, 1, 0);
    chk("glitch pulses", fv_cnt, 1);
    chk("frame_valid idle", frame_valid, 0);

    // Reset in the middle of a partial frame.
    drive(4'b1110, D7, 16);
    drive(4'b1101, D1, 16);
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0);
    chk("midreset frame_valid", frame_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, BAD, 4);
    fv_cnt = 0;
    scan({D2, D0, D1, D5}, 2, 1'b0);
    chk_all("after reset", 20, 15, 1, 1, 0);
    chk("after reset pulses", fv_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
